// File: rtl/bcd_encoder_if.sv
// Handshake and data bus of bcd_encoder: the controller drives start/bin_in
// and reads back busy/done/bcd_out.
interface bcd_encoder_if #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
);
    logic                start;
    logic [WIDTH-1:0]    bin_in;
    logic                busy;
    logic                done;
    logic [4*DIGITS-1:0] bcd_out;

    modport master (output start, bin_in, input  busy, done, bcd_out);
    modport slave  (input  start, bin_in, output busy, done, bcd_out);
endinterface

// File: rtl/bcd_encoder.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// Define BCD_ENCODER_BLANK_EN to show leading zero digits as 4'hF (blank).
module bcd_encoder_dig (
    input  logic [3:0] d,
    output logic [3:0] q
);
    assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

module bcd_encoder #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input logic          clk,
    input logic          resetn,
    bcd_encoder_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int SW = 4 * DIGITS;

    function automatic logic [SW-1:0] rst_pattern();
        logic [SW-1:0] p;
        p = '0;
`ifdef BCD_ENCODER_BLANK_EN
        for (int i = 1; i < DIGITS; i++) p[4*i +: 4] = 4'hF;
`endif
        return p;
    endfunction

    localparam logic [SW-1:0] RST_BCD = rst_pattern();

    // Digits above the most significant nonzero one become 4'hF; digit 0 always shows.
    function automatic logic [SW-1:0] fmt(input logic [SW-1:0] d);
        logic [SW-1:0] r;
        r = d;
`ifdef BCD_ENCODER_BLANK_EN
        begin
            logic lead;
            lead = 1'b1;
            for (int i = DIGITS - 1; i >= 1; i--) begin
                if (d[4*i +: 4] != 4'd0) lead = 1'b0;
                if (lead) r[4*i +: 4] = 4'hF;
            end
        end
`endif
        return r;
    endfunction

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01
    } state_t;

    state_t          state, state_nxt;
    logic [SW-1:0]   scratch, adj, scr_nxt;
    logic [WIDTH-1:0] sr, sr_nxt;
    logic [CW-1:0]   cnt;
    logic            busy_r, done_r, busy_nxt, done_nxt, load;
    logic [SW-1:0]   bcd_r;
    logic            last;

    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        bcd_encoder_dig u_dig (.d(scratch[4*g +: 4]), .q(adj[4*g +: 4]));
    end

    // Correction first, then one left shift of {digits, binary}.
    assign {scr_nxt, sr_nxt} = {adj[SW-2:0], sr, 1'b0};
    assign last = (state == SHIFT) && (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE:    state_nxt = bus.start ? SHIFT : IDLE;
            SHIFT:   state_nxt = last ? IDLE : SHIFT;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy_nxt = 1'b0;
        done_nxt = 1'b0;
        load     = 1'b0;
        case (state)
            IDLE:  busy_nxt = bus.start;
            SHIFT: begin
                busy_nxt = !last;
                done_nxt = last;
                load     = last;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            scratch <= '0;
            sr      <= '0;
            cnt     <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            bcd_r   <= RST_BCD;
        end else begin
            busy_r <= busy_nxt;
            done_r <= done_nxt;
            case (state)
                IDLE: begin
                    sr      <= bus.bin_in;
                    scratch <= '0;
                    cnt     <= '0;
                end
                SHIFT: begin
                    sr      <= sr_nxt;
                    scratch <= scr_nxt;
                    cnt     <= cnt + CW'(1);
                end
                default: begin
                    sr      <= '0;
                    scratch <= '0;
                    cnt     <= '0;
                end
            endcase
            if (load) bcd_r <= fmt(scr_nxt);
        end
    end

    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.bcd_out = bcd_r;
endmodule
